// File: rtl/fadd_pkg.sv
// rtl/fadd_pkg.sv - shared rounding modes, flag indices and stage-1 status bundle for the fp adder
package fadd_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    // Width-independent part of the stage-1 output register
    typedef struct packed {
        logic special_case_valid;
        logic special_case_iv;
        logic special_case_nan;
        logic special_case_inf_sign;
        logic small_add;
        logic far_mul_of;
        logic near_sig_is_zero;
        logic sel_far_path;
    } s1_status_t;

endpackage

// File: rtl/fadd_rounder.sv
// rtl/fadd_rounder.sv - combinational significand rounder: {sign, sig+R+S, rm} -> {rounded sig, carry-out, inexact}
module fadd_rounder
    import fadd_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         sign,
    input  logic [W+1:0] sig,
    input  logic [2:0]   rm,
    output logic [W-1:0] rnd_sig,
    output logic         cout,
    output logic         inexact
);

    logic lsb, rnd, stk, inc;

    assign lsb = sig[2];
    assign rnd = sig[1];
    assign stk = sig[0];

    always_comb begin
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & (rnd | stk);
            RM_RUP:  inc = ~sign & (rnd | stk);
            RM_RMM:  inc = rnd;
            default: inc = rnd & (stk | lsb);
        endcase
    end

    assign {cout, rnd_sig} = {1'b0, sig[W+1:2]} + {{W{1'b0}}, inc};
    assign inexact = rnd | stk;

endmodule

// File: rtl/fadd_s2.sv
// rtl/fadd_s2.sv - fp adder final stage: path select, normalize, round, specials; optional skid via FADD_S2_SKID_EN
module fadd_s2
    import fadd_pkg::*;
#(
    parameter int EXPWIDTH  = 5,
    parameter int PRECISION = 8,
    parameter int OUTPC     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [2:0]                rm_i,
    input  logic                      far_sign_i,
    input  logic [EXPWIDTH-1:0]       far_exp_i,
    input  logic [OUTPC+2:0]          far_sig_i,
    input  logic                      near_sign_i,
    input  logic [EXPWIDTH-1:0]       near_exp_i,
    input  logic [OUTPC+2:0]          near_sig_i,
    input  logic                      special_case_valid_i,
    input  logic                      special_case_iv_i,
    input  logic                      special_case_nan_i,
    input  logic                      special_case_inf_sign_i,
    input  logic                      small_add_i,
    input  logic                      far_mul_of_i,
    input  logic                      near_sig_is_zero_i,
    input  logic                      sel_far_path_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [EXPWIDTH+OUTPC-1:0] result_o,
    output logic [4:0]                fflags_o
);

    localparam logic [EXPWIDTH:0]   EXP_ONES  = {1'b0, {EXPWIDTH{1'b1}}};
    localparam logic [EXPWIDTH-1:0] EXP_MAXF  = {{(EXPWIDTH-1){1'b1}}, 1'b0};
    localparam logic [OUTPC-2:0]    QNAN_FRAC = {1'b1, {(OUTPC-2){1'b0}}};

    // PRECISION is carried for stage-1 compatibility only
    if (PRECISION < 1) begin : g_precision_unused
    end

    s1_status_t st;
    assign st = '{special_case_valid:    special_case_valid_i,
                  special_case_iv:       special_case_iv_i,
                  special_case_nan:      special_case_nan_i,
                  special_case_inf_sign: special_case_inf_sign_i,
                  small_add:             small_add_i,
                  far_mul_of:            far_mul_of_i,
                  near_sig_is_zero:      near_sig_is_zero_i,
                  sel_far_path:          sel_far_path_i};

    logic                      sign_sel;
    logic [EXPWIDTH-1:0]       exp_sel;
    logic [OUTPC+2:0]          sig_sel;
    logic [OUTPC+1:0]          sig_norm;
    logic [EXPWIDTH:0]         exp_norm, exp_fin;
    logic [OUTPC-1:0]          rnd_sig, sig_fin;
    logic                      rnd_cout, rnd_nx, ovf, ovf_inf;
    logic [EXPWIDTH+OUTPC-1:0] res_d;
    logic [4:0]                flags_d;

    assign sign_sel = st.sel_far_path ? far_sign_i : near_sign_i;
    assign exp_sel  = st.sel_far_path ? far_exp_i  : near_exp_i;
    assign sig_sel  = st.sel_far_path ? far_sig_i  : near_sig_i;

    // A carry-out shifts right once; the dropped bit folds into sticky
    assign sig_norm = sig_sel[OUTPC+2] ? {sig_sel[OUTPC+2:2], sig_sel[1] | sig_sel[0]}
                                       : sig_sel[OUTPC+1:0];
    assign exp_norm = {1'b0, exp_sel} + {{EXPWIDTH{1'b0}}, sig_sel[OUTPC+2]};

    fadd_rounder #(.W(OUTPC)) u_rounder (
        .sign    (sign_sel),
        .sig     (sig_norm),
        .rm      (rm_i),
        .rnd_sig (rnd_sig),
        .cout    (rnd_cout),
        .inexact (rnd_nx)
    );

    // On rounding carry-out the low bits are already zero, so only the hidden bit needs forcing
    assign sig_fin = {rnd_cout | rnd_sig[OUTPC-1], rnd_sig[OUTPC-2:0]};
    assign exp_fin = st.small_add ? {{EXPWIDTH{1'b0}}, sig_fin[OUTPC-1]}
                                  : exp_norm + {{EXPWIDTH{1'b0}}, rnd_cout};

    assign ovf = (st.sel_far_path & st.far_mul_of) | (exp_fin >= EXP_ONES);

    always_comb begin
        case (rm_i)
            RM_RTZ:  ovf_inf = 1'b0;
            RM_RDN:  ovf_inf = sign_sel;
            RM_RUP:  ovf_inf = ~sign_sel;
            default: ovf_inf = 1'b1;
        endcase
    end

    always_comb begin
        res_d = {sign_sel, exp_fin[EXPWIDTH-1:0], sig_fin[OUTPC-2:0]};
        flags_d = 5'b0;
        flags_d[FF_NX] = rnd_nx;
        flags_d[FF_UF] = rnd_nx && (exp_fin == '0);
        if (st.special_case_nan) begin
            res_d = {1'b0, {EXPWIDTH{1'b1}}, QNAN_FRAC};
            flags_d = 5'b0;
            flags_d[FF_NV] = st.special_case_iv;
        end else if (st.special_case_valid) begin
            res_d = {st.special_case_inf_sign, {EXPWIDTH{1'b1}}, {(OUTPC-1){1'b0}}};
            flags_d = 5'b0;
        end else if (ovf) begin
            res_d = ovf_inf ? {sign_sel, {EXPWIDTH{1'b1}}, {(OUTPC-1){1'b0}}}
                            : {sign_sel, EXP_MAXF, {(OUTPC-1){1'b1}}};
            flags_d = 5'b0;
            flags_d[FF_OF] = 1'b1;
            flags_d[FF_NX] = 1'b1;
        end else if (!st.sel_far_path && st.near_sig_is_zero) begin
            res_d = {rm_i == RM_RDN, {(EXPWIDTH+OUTPC-1){1'b0}}};
            flags_d = 5'b0;
        end
    end

    logic in_fire;
    assign in_fire = in_valid_i && in_ready_o;

`ifdef FADD_S2_SKID_EN
    logic                      skid_full, in_ready_q;
    logic [EXPWIDTH+OUTPC-1:0] skid_res;
    logic [4:0]                skid_flags;

    assign in_ready_o = in_ready_q;

    // Ready is registered, so a beat accepted during a stall parks in the skid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_o <= 1'b0;
            result_o    <= '0;
            fflags_o    <= '0;
            skid_full   <= 1'b0;
            skid_res    <= '0;
            skid_flags  <= '0;
            in_ready_q  <= 1'b1;
        end else if (!out_valid_o || out_ready_i) begin
            if (skid_full) begin
                result_o    <= skid_res;
                fflags_o    <= skid_flags;
                out_valid_o <= 1'b1;
                skid_full   <= 1'b0;
                in_ready_q  <= 1'b1;
            end else begin
                out_valid_o <= in_fire;
                if (in_fire) begin
                    result_o <= res_d;
                    fflags_o <= flags_d;
                end
            end
        end else if (in_fire) begin
            skid_res   <= res_d;
            skid_flags <= flags_d;
            skid_full  <= 1'b1;
            in_ready_q <= 1'b0;
        end
    end
`else
    assign in_ready_o = out_ready_i || !out_valid_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_o <= 1'b0;
            result_o    <= '0;
            fflags_o    <= '0;
        end else if (in_fire) begin
            out_valid_o <= 1'b1;
            result_o    <= res_d;
            fflags_o    <= flags_d;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end
`endif

endmodule
